// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write engine (lcd_ctrl).
// Optional input FIFO is enabled by defining LCD_FIFO_EN.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP_WAIT,
        INIT_LOAD,
        SETUP,
        PULSE,
        HOLD,
        EXEC,
        IDLE
    } lcd_state_e;

    localparam logic [7:0] LCD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_HOME    = 8'h02;
    localparam int         INIT_LEN    = 4;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = LCD_FUNCSET;
            2'd1:    b = LCD_DISPON;
            2'd2:    b = LCD_ENTRY;
            default: b = LCD_CLEAR;
        endcase
        return b;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// Byte-write handshake between proc (master) and lcd_ctrl (slave).
interface lcd_ctrl_if;
    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_fifo.sv
// Small synchronous FIFO buffering {rs, data} ahead of the LCD engine.
// Used only when LCD_FIFO_EN is defined; DEPTH must be a power of 2.
module lcd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          push_ok, pop_ok;

    // A push into a full FIFO is refused even when a pop happens the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rp_q];

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wp_q <= wp_q + 1'b1;
            if (pop_ok)  rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit write-only engine: power-up init, then RS/E/data timing per byte.
// Define LCD_FIFO_EN to buffer incoming bytes in lcd_fifo (writes accepted during init).
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int PWRUP_CYC  = 750000,
    parameter int SETUP_CYC  = 4,
    parameter int EN_CYC     = 24,
    parameter int HOLD_CYC   = 4,
    parameter int EXEC_CYC   = 2000,
    parameter int CLR_CYC    = 82000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    lcd_ctrl_if.slave      wr,
    output logic           init_done,
    output logic           busy,
    output logic [7:0]     LCD,
    output logic           lcdRS,
    output logic           lcdRW,
    output logic           lcdEn
);
    localparam int MAXC = max_int(max_int(max_int(PWRUP_CYC, SETUP_CYC), max_int(EN_CYC, HOLD_CYC)),
                                  max_int(EXEC_CYC, CLR_CYC));
    localparam int CW   = $clog2(MAXC) + 1;
    // Reset leaves the counter at 0, so power-up counts down through the wrap:
    // the last of PWRUP_CYC cycles sees 0 - (PWRUP_CYC-1).
    localparam logic [CW-1:0] PWR_END = CW'((1 << CW) - PWRUP_CYC + 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2");
    end

    lcd_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d, en_q, en_d, done_q, done_d;
    logic          src_valid, src_rs, take, is_clr;
    logic [7:0]    src_data;

    assign take = (state_q == IDLE) && done_q && src_valid;

`ifdef LCD_FIFO_EN
    logic fifo_full, fifo_empty;

    lcd_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr.wr_valid),
        .din_i   ({wr.wr_rs, wr.wr_data}),
        .pop_i   (take),
        .dout_o  ({src_rs, src_data}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign src_valid   = !fifo_empty;
    assign wr.wr_ready = !fifo_full;
`else
    assign src_valid   = wr.wr_valid;
    assign src_rs      = wr.wr_rs;
    assign src_data    = wr.wr_data;
    assign wr.wr_ready = (state_q == IDLE) && done_q;
`endif

    assign is_clr = !rs_q && (data_q == LCD_CLEAR || data_q == LCD_HOME || data_q == 8'h03);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 1'b1;
        idx_d   = idx_q;
        data_d  = data_q;
        rs_d    = rs_q;
        en_d    = 1'b0;
        done_d  = done_q;
        unique case (state_q)
            PWRUP_WAIT: if (cnt_q == PWR_END) state_d = INIT_LOAD;
            INIT_LOAD: begin
                data_d  = init_byte(idx_q[1:0]);
                rs_d    = 1'b0;
                idx_d   = idx_q + 3'd1;
                state_d = SETUP;
                cnt_d   = CW'(SETUP_CYC - 1);
            end
            SETUP: if (cnt_q == '0) begin
                state_d = PULSE;
                cnt_d   = CW'(EN_CYC - 1);
                en_d    = 1'b1;
            end
            PULSE: begin
                en_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CW'(HOLD_CYC - 1);
                    en_d    = 1'b0;
                end
            end
            HOLD: if (cnt_q == '0) begin
                state_d = EXEC;
                cnt_d   = is_clr ? CW'(CLR_CYC - 1) : CW'(EXEC_CYC - 1);
            end
            EXEC: if (cnt_q == '0) begin
                if (idx_q < 3'(INIT_LEN)) begin
                    state_d = INIT_LOAD;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cnt_d = cnt_q;
                if (take) begin
                    data_d  = src_data;
                    rs_d    = src_rs;
                    state_d = SETUP;
                    cnt_d   = CW'(SETUP_CYC - 1);
                end
            end
            default: state_d = PWRUP_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PWRUP_WAIT;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    assign LCD       = data_q;
    assign lcdRS     = rs_q;
    assign lcdRW     = 1'b0;
    assign lcdEn     = en_q;
    assign init_done = done_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_lcd_ctrl.sv
// Scenario bench for lcd_ctrl with shortened timing; LCD_FIFO_EN selects the FIFO scenarios.
module tb_lcd_ctrl;
    localparam int P_PWR = 20, P_SU = 2, P_EN = 3, P_HD = 2, P_EX = 5, P_CLR = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_done, busy, lcdRS, lcdRW, lcdEn;
    logic [7:0] LCD;

    lcd_ctrl_if wr_if ();

    lcd_ctrl #(
        .PWRUP_CYC(P_PWR), .SETUP_CYC(P_SU), .EN_CYC(P_EN), .HOLD_CYC(P_HD),
        .EXEC_CYC(P_EX), .CLR_CYC(P_CLR), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .wr(wr_if), .init_done(init_done), .busy(busy),
        .LCD(LCD), .lcdRS(lcdRS), .lcdRW(lcdRW), .lcdEn(lcdEn)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0, n_bad = 0, n_pulse = 0;
    logic       rw_hi = 1'b0, mon_prev = 1'b0;
    logic [8:0] mon_exp;
    logic [8:0] sb[$];

    // Scoreboard consumer: every rising lcdEn must match the next expected {rs, byte}.
    initial begin
        forever begin
            @(negedge clk);
            if (lcdRW !== 1'b0) rw_hi = 1'b1;
            if (lcdEn === 1'b1 && !mon_prev) begin
                n_pulse++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL pulse_unexpected: got rs=%0b data=%02h, required no pulse", lcdRS, LCD);
                end else begin
                    mon_exp = sb.pop_front();
                    if ({lcdRS, LCD} !== mon_exp) begin
                        n_bad++;
                        $display("FAIL pulse_byte: got rs=%0b data=%02h, required rs=%0b data=%02h",
                                 lcdRS, LCD, mon_exp[8], mon_exp[7:0]);
                    end
                end
            end
            mon_prev = lcdEn;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_init();
        sb.push_back({1'b0, 8'h38});
        sb.push_back({1'b0, 8'h0C});
        sb.push_back({1'b0, 8'h06});
        sb.push_back({1'b0, 8'h01});
    endtask

    // Counts negedges after reset release to the first lcdEn and from the last lcdEn fall to init_done.
    task automatic run_init(output int first, output int gap);
        int   cyc = 0, last_fall = -1;
        logic prev = 1'b0;
        first = -1;
        while (init_done !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (lcdEn && !prev && first < 0) first = cyc;
            if (!lcdEn && prev) last_fall = cyc;
            prev = lcdEn;
        end
        gap = cyc - last_fall;
    endtask

    // Sends one byte in IDLE; reports wr_ready-low span, lcdEn rise offset, lcdEn high count, bus after accept.
    task automatic xfer(input logic rs, input logic [7:0] d,
                        output int low, output int rise, output int hi, output logic [8:0] bus);
        int k = 0, w = 0;
        while (wr_if.wr_ready !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
        wr_if.wr_valid = 1'b1; wr_if.wr_rs = rs; wr_if.wr_data = d;
        sb.push_back({rs, d});
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        bus = {lcdRS, LCD};
        low = 0; rise = -1; hi = 0;
        while (wr_if.wr_ready !== 1'b1 && k < 1000) begin
            k++; low++;
            if (lcdEn) begin hi++; if (rise < 0) rise = k; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic exp_rdy;
`ifdef LCD_FIFO_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = 1'b0;
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp += 7;
        if (LCD !== 8'h00)            begin n_bad++; $display("FAIL rst_LCD: got %02h, required 00", LCD); end
        if (lcdRS !== 1'b0)           begin n_bad++; $display("FAIL rst_lcdRS: got %0b, required 0", lcdRS); end
        if (lcdRW !== 1'b0)           begin n_bad++; $display("FAIL rst_lcdRW: got %0b, required 0", lcdRW); end
        if (lcdEn !== 1'b0)           begin n_bad++; $display("FAIL rst_lcdEn: got %0b, required 0", lcdEn); end
        if (wr_if.wr_ready !== exp_rdy) begin n_bad++; $display("FAIL rst_wr_ready: got %0b, required %0b", wr_if.wr_ready, exp_rdy); end
        if (init_done !== 1'b0)       begin n_bad++; $display("FAIL rst_init_done: got %0b, required 0", init_done); end
        if (busy !== 1'b1)            begin n_bad++; $display("FAIL rst_busy: got %0b, required 1", busy); end
    endtask

    task automatic test_init();
        int first, gap;
        push_init();
        reset = 1'b0;
        run_init(first, gap);
        n_cmp += 5;
        if (first != P_PWR + 1 + P_SU) begin n_bad++; $display("FAIL init_first_en: got cycle %0d, required %0d", first, P_PWR + 1 + P_SU); end
        if (init_done !== 1'b1) begin n_bad++; $display("FAIL init_done_timeout: got %0b, required 1", init_done); end
        if (gap != P_HD + P_CLR) begin n_bad++; $display("FAIL init_done_delay: got %0d, required %0d", gap, P_HD + P_CLR); end
        if (sb.size() != 0) begin n_bad++; $display("FAIL init_pulses: got %0d missing, required 0", sb.size()); end
        if (busy !== 1'b0 || wr_if.wr_ready !== 1'b1) begin n_bad++; $display("FAIL init_idle: got busy=%0b ready=%0b, required 0/1", busy, wr_if.wr_ready); end
    endtask

    task automatic test_data_write();
        int low, rise, hi; logic [8:0] bus;
        xfer(1'b1, 8'h41, low, rise, hi, bus);
        n_cmp += 4;
        if (bus !== 9'h141) begin n_bad++; $display("FAIL data_bus: got %03h, required 141", bus); end
        if (rise != P_SU + 1) begin n_bad++; $display("FAIL data_en_start: got %0d, required %0d", rise, P_SU + 1); end
        if (hi != P_EN) begin n_bad++; $display("FAIL data_en_width: got %0d, required %0d", hi, P_EN); end
        if (low != P_SU + P_EN + P_HD + P_EX) begin n_bad++; $display("FAIL data_busy_span: got %0d, required %0d", low, P_SU + P_EN + P_HD + P_EX); end
    endtask

    task automatic test_cmds();
        int low, rise, hi; logic [8:0] bus;
        xfer(1'b0, 8'h01, low, rise, hi, bus);
        n_cmp += 2;
        if (bus !== 9'h001) begin n_bad++; $display("FAIL clr_bus: got %03h, required 001", bus); end
        if (low != P_SU + P_EN + P_HD + P_CLR) begin n_bad++; $display("FAIL clr_busy_span: got %0d, required %0d", low, P_SU + P_EN + P_HD + P_CLR); end
        xfer(1'b0, 8'h80, low, rise, hi, bus);
        n_cmp += 2;
        if (bus !== 9'h080) begin n_bad++; $display("FAIL cmd80_bus: got %03h, required 080", bus); end
        if (low != P_SU + P_EN + P_HD + P_EX) begin n_bad++; $display("FAIL cmd80_busy_span: got %0d, required %0d", low, P_SU + P_EN + P_HD + P_EX); end
    endtask

    task automatic test_back_to_back();
        int n0 = n_pulse, w = 0;
        wr_if.wr_valid = 1'b1; wr_if.wr_rs = 1'b1; wr_if.wr_data = 8'h48;
        sb.push_back(9'h148);
        while (wr_if.wr_ready !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
        @(negedge clk);
        wr_if.wr_data = 8'h49;
        sb.push_back(9'h149);
        w = 0;
        while (wr_if.wr_ready !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        w = 0;
        while (wr_if.wr_ready !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
        n_cmp += 2;
        if (n_pulse - n0 != 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d, required 2", n_pulse - n0); end
        if (sb.size() != 0) begin n_bad++; $display("FAIL b2b_pending: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        int first, gap, n0, w = 0;
        sb.delete();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        sb.push_back(9'h038);
`ifdef LCD_FIFO_EN
        // Queued during power-up; the mid-pulse reset must discard it.
        wr_if.wr_valid = 1'b1; wr_if.wr_rs = 1'b1; wr_if.wr_data = 8'h5A;
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
`endif
        while (lcdEn !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp += 4;
        if (lcdEn !== 1'b0) begin n_bad++; $display("FAIL mid_rst_en: got %0b, required 0", lcdEn); end
        if ({lcdRS, LCD} !== 9'h000) begin n_bad++; $display("FAIL mid_rst_bus: got %03h, required 000", {lcdRS, LCD}); end
        if (busy !== 1'b1 || init_done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flags: got busy=%0b done=%0b, required 1/0", busy, init_done); end
        if (sb.size() != 0) begin n_bad++; $display("FAIL mid_rst_prior_pulse: got %0d pending, required 0", sb.size()); end
        n0 = n_pulse;
        push_init();
        run_init(first, gap);
        repeat (30) @(negedge clk);
        n_cmp += 3;
        if (first != P_PWR + 1 + P_SU) begin n_bad++; $display("FAIL mid_rst_restart: got cycle %0d, required %0d", first, P_PWR + 1 + P_SU); end
        if (init_done !== 1'b1) begin n_bad++; $display("FAIL mid_rst_done: got %0b, required 1", init_done); end
        if (n_pulse - n0 != 4) begin n_bad++; $display("FAIL mid_rst_pulses: got %0d, required 4", n_pulse - n0); end
    endtask

`ifdef LCD_FIFO_EN
    task automatic test_fifo();
        int n0, w = 0;
        logic exp_rdy;
        sb.delete();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        n0 = n_pulse;
        push_init();
        for (int i = 0; i < 5; i++) begin
            exp_rdy = (i < 4);
            n_cmp++;
            if (wr_if.wr_ready !== exp_rdy) begin n_bad++; $display("FAIL fifo_ready_%0d: got %0b, required %0b", i, wr_if.wr_ready, exp_rdy); end
            wr_if.wr_valid = 1'b1; wr_if.wr_rs = 1'b1; wr_if.wr_data = 8'h30 + 8'(i);
            if (i < 4) sb.push_back({1'b1, 8'h30 + 8'(i)});
            @(negedge clk);
        end
        wr_if.wr_valid = 1'b0;
        n_cmp++;
        if (wr_if.wr_ready !== 1'b0) begin n_bad++; $display("FAIL fifo_full_hold: got %0b, required 0", wr_if.wr_ready); end
        while ((sb.size() != 0 || busy !== 1'b0) && w < 3000) begin @(negedge clk); w++; end
        repeat (20) @(negedge clk);
        n_cmp += 3;
        if (sb.size() != 0) begin n_bad++; $display("FAIL fifo_pending: got %0d, required 0", sb.size()); end
        if (n_pulse - n0 != 8) begin n_bad++; $display("FAIL fifo_pulses: got %0d, required 8", n_pulse - n0); end
        if (wr_if.wr_ready !== 1'b1) begin n_bad++; $display("FAIL fifo_drained_ready: got %0b, required 1", wr_if.wr_ready); end
    endtask
`endif

    task automatic test_rw();
        n_cmp++;
        if (rw_hi !== 1'b0) begin n_bad++; $display("FAIL lcdRW_const: got high at some cycle, required 0 throughout"); end
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_rs    = 1'b0;
        wr_if.wr_data  = 8'h00;
        test_reset();
        test_init();
`ifndef LCD_FIFO_EN
        test_data_write();
        test_cmds();
        test_back_to_back();
`endif
        test_reset_mid();
`ifdef LCD_FIFO_EN
        test_fifo();
`endif
        test_rw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Character-LCD write engine (HD44780-compatible, 8-bit bus, write-only) directly downstream of proc.
- proc issues command/data bytes over a valid/ready handshake.
- lcd_ctrl runs the power-up init sequence, then generates RS/RW/E/data timing and execution waits for each byte.
- Owns the board-level LCD, lcdRS, lcdRW and lcdEn pins.

Parameters:
- PWRUP_CYC, 750000, cycles to wait after reset before the first init command (15 ms at 50 MHz).
- SETUP_CYC, 4, cycles RS/data are stable before lcdEn rises.
- EN_CYC, 24, cycles lcdEn is held high.
- HOLD_CYC, 4, cycles RS/data are held after lcdEn falls.
- EXEC_CYC, 2000, post-write wait for normal commands and data.
- CLR_CYC, 82000, post-write wait for clear/home commands.
- FIFO_DEPTH, 4, input FIFO entries; power of 2; used only with LCD_FIFO_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  proc presents a byte
- wr_rs  in  1  0 = command, 1 = data
- wr_data  in  8  byte to write
- wr_ready  out  1  block accepts the byte this cycle
- init_done  out  1  init sequence complete
- busy  out  1  transfer or wait in progress
- LCD  out  8  LCD data bus
- lcdRS  out  1  register select
- lcdRW  out  1  read/write; tied 0
- lcdEn  out  1  enable strobe

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: LCD=0x00, lcdRS=0, lcdRW=0, lcdEn=0, wr_ready=0, init_done=0, busy=1, state=PWRUP_WAIT, counter=0.
- Reset asserted mid-transfer: lcdEn low at the next edge; any queued or in-flight byte is discarded.
- Counter: single down-counter, width $clog2 of the largest timing parameter, plus 1.
- PWRUP_WAIT: count PWRUP_CYC cycles, then go to INIT_LOAD.
- INIT_LOAD: load the next ROM entry (RS=0): 0x38, 0x0C, 0x06, 0x01. Go to SETUP.
- SETUP: drive LCD/lcdRS from the current byte for SETUP_CYC cycles, then go to PULSE.
- PULSE: lcdEn=1 for EN_CYC cycles, then go to HOLD.
- HOLD: lcdEn=0, bus unchanged for HOLD_CYC cycles, then go to EXEC.
- EXEC wait length:
  - CLR_CYC if RS=0 and byte is 0x01, 0x02 or 0x03;
  - otherwise EXEC_CYC.
- After EXEC:
  - if init index < 4, go to INIT_LOAD;
  - otherwise set init_done=1 (sticky until reset) and go to IDLE.
- IDLE: busy=0. Without the FIFO, wr_ready=1 only here and only when init_done=1.
- Accept: wr_valid & wr_ready at edge N. SETUP entered at N+1 with LCD/lcdRS updated. lcdEn rises at N+1+SETUP_CYC.
- Occupancy per byte: SETUP_CYC+EN_CYC+HOLD_CYC+wait cycles; wr_ready is low for that whole span.
- LCD/lcdRS keep their last value in IDLE.
- wr_valid while wr_ready=0 is ignored. proc must hold the byte until accepted.

Optional Feature:
- Macro: LCD_FIFO_EN.
- Defined:
  - a FIFO_DEPTH-entry FIFO (lcd_fifo) buffers {wr_rs, wr_data};
  - wr_ready = !full, independent of state and init_done, so writes may be queued during init;
  - the engine pops only in IDLE with init_done=1 and FIFO non-empty (pop at edge N, SETUP at N+1);
  - a push into a full FIFO is refused even if a pop happens the same cycle;
  - push and pop in the same cycle on a non-full FIFO are both performed;
  - pointers wrap modulo FIFO_DEPTH; reset flushes the FIFO.
- Undefined: no FIFO; direct handshake as above.

Decomposition:
- lcd_pkg holds:
  - state enum {PWRUP_WAIT, INIT_LOAD, SETUP, PULSE, HOLD, EXEC, IDLE};
  - init ROM constants LCD_FUNCSET=0x38, LCD_DISPON=0x0C, LCD_ENTRY=0x06, LCD_CLEAR=0x01, LCD_HOME=0x02;
  - INIT_LEN=4.
- Sub-module: lcd_fifo (sync FIFO, 9-bit entries), instantiated only under LCD_FIFO_EN.

Test Plan:
Timing parameters for all scenarios: PWRUP=20, SETUP=2, EN=3, HOLD=2, EXEC=5, CLR=10.
1. Reset release:
   - no lcdEn for 20 cycles;
   - then 4 pulses with LCD=0x38, 0x0C, 0x06, 0x01 and lcdRS=0;
   - init_done rises after the 0x01 pulse plus 10 wait cycles.
2. Data write 0x41, RS=1, after init:
   - lcdEn high exactly 3 cycles, starting 2 cycles after LCD=0x41 and lcdRS=1;
   - wr_ready low for 12 cycles.
3. Command 0x01 after init: wr_ready low 17 cycles. Command 0x80: wr_ready low 12 cycles.
4. wr_valid held high with RS=1 and bytes 0x48, then 0x49 (each advanced on accept): two back-to-back transfers, no byte lost or duplicated, lcdRW=0 throughout.
5. Reset asserted during PULSE:
   - lcdEn=0 on the next cycle, outputs at reset values;
   - init sequence restarts from PWRUP_WAIT.
6. With LCD_FIFO_EN, FIFO_DEPTH=4:
   - 5 writes during init: wr_ready low after the 4th;
   - the 4 bytes appear on LCD in order after init_done.
